// File: rtl/dllp_acknak_if.sv
// Bus bundle between the link receive path / replay buffer and dllp_acknak_rx.
//   din, din_valid, sof : 16-bit link words and qualifiers (into the decoder)
//   unacked             : replay buffer holds unacknowledged TLPs (into the decoder)
//   ack_nack, seq       : decoded Ack/Nak pulse and AckNak_Seq_Num (to replay buffer)
//   tim_out, retrain    : replay-timeout pulse and retrain request
//   crc_err, fmt_err    : per-DLLP error pulses
//   err_cnt             : saturating error count
// master drives the link side; slave is the decoder.
interface dllp_acknak_if;
  logic [15:0] din;
  logic        din_valid;
  logic        sof;
  logic        unacked;
  logic [1:0]  ack_nack;
  logic [11:0] seq;
  logic        tim_out;
  logic        retrain;
  logic        crc_err;
  logic        fmt_err;
  logic [7:0]  err_cnt;

  modport master (
    output din, din_valid, sof, unacked,
    input  ack_nack, seq, tim_out, retrain, crc_err, fmt_err, err_cnt
  );

  modport slave (
    input  din, din_valid, sof, unacked,
    output ack_nack, seq, tim_out, retrain, crc_err, fmt_err, err_cnt
  );
endinterface

// File: rtl/dllp_acknak_rx.sv
// Receive-side Ack/Nak DLLP decoder and replay timer.
// Assembles three 16-bit words ({type,8'h00}, {4'h0,seq}, CRC) into a DLLP,
// checks the CRC (poly 0x100B, init 16'hFFFF, word2 = ~register) and emits a
// one-cycle ack_nack/seq pulse for good Ack/Nak packets. A replay timer fires
// tim_out after REPLAY_LIMIT cycles of unacknowledged traffic and a 2-bit
// replay count requests retrain on every 4th consecutive timeout.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : dllp_acknak_if.slave (link words in, decode/timer/error results out)
// All outputs are registered.
module dllp_acknak_rx #(
  parameter int REPLAY_LIMIT = 1024
) (
  input  logic           clk,
  input  logic           rst,
  dllp_acknak_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_W1, S_W2} state_e;

  localparam logic [7:0]  TYPE_ACK = 8'h00;
  localparam logic [7:0]  TYPE_NAK = 8'h10;
  localparam logic [15:0] LIMIT    = 16'(REPLAY_LIMIT);

  // Advance the CRC register by one 16-bit word, MSB first.
  function automatic logic [15:0] crc_word(input logic [15:0] crc_in,
                                           input logic [15:0] w);
    logic [15:0] c;
    logic        fb;
    c = crc_in;
    for (int i = 15; i >= 0; i--) begin
      fb = c[15] ^ w[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h100B : 16'h0000);
    end
    return c;
  endfunction

  state_e      state_q, state_d;
  logic [7:0]  type_q, type_d;
  logic [11:0] seq_buf_q, seq_buf_d;
  logic [15:0] crc_q, crc_d;
  logic [1:0]  ack_nack_q, ack_nack_d;
  logic [11:0] seq_q, seq_d;
  logic        tim_out_q, tim_out_d;
  logic        retrain_q, retrain_d;
  logic        crc_err_q, crc_err_d;
  logic        fmt_err_q, fmt_err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [15:0] timer_q, timer_d;
  logic [1:0]  rply_cnt_q, rply_cnt_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d    = state_q;
    type_d     = type_q;
    seq_buf_d  = seq_buf_q;
    crc_d      = crc_q;
    ack_nack_d = 2'b00;
    seq_d      = seq_q;
    tim_out_d  = 1'b0;
    retrain_d  = 1'b0;
    crc_err_d  = 1'b0;
    fmt_err_d  = 1'b0;
    err_cnt_d  = err_cnt_q;
    timer_d    = timer_q;
    rply_cnt_d = rply_cnt_q;

    // ---- DLLP assembly ----
    if (bus.din_valid) begin
      if (bus.sof) begin
        // sof always starts a new DLLP; a partial one in flight is a format error.
        fmt_err_d = (state_q != S_IDLE);
        type_d    = bus.din[15:8];
        crc_d     = crc_word(16'hFFFF, bus.din);
        state_d   = S_W1;
      end else begin
        unique case (state_q)
          S_IDLE: ; // stray word outside a DLLP is dropped
          S_W1: begin
            seq_buf_d = bus.din[11:0];
            crc_d     = crc_word(crc_q, bus.din);
            state_d   = S_W2;
          end
          S_W2: begin
            state_d = S_IDLE;
            if (bus.din != ~crc_q) begin
              crc_err_d = 1'b1;
            end else if (type_q == TYPE_ACK) begin
              ack_nack_d = 2'b01;
              seq_d      = seq_buf_q;
            end else if (type_q == TYPE_NAK) begin
              ack_nack_d = 2'b10;
              seq_d      = seq_buf_q;
            end else begin
              fmt_err_d = 1'b1;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end

    // ---- Replay timer: a decoded Ack/Nak outranks an expiring timer ----
    if (!bus.unacked || ack_nack_d != 2'b00) begin
      timer_d = 16'd0;
    end else if (timer_q + 16'd1 == LIMIT) begin
      timer_d   = 16'd0;
      tim_out_d = 1'b1;
    end else begin
      timer_d = timer_q + 16'd1;
    end

    // ---- Replay count: wraps 3 -> 0 on the retrain timeout ----
    if (ack_nack_d == 2'b01) begin
      rply_cnt_d = 2'd0;
    end else if (tim_out_d) begin
      retrain_d  = (rply_cnt_q == 2'd3);
      rply_cnt_d = rply_cnt_q + 2'd1;
    end

    if ((crc_err_d || fmt_err_d) && err_cnt_q != 8'hFF) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q    <= S_IDLE;
      ack_nack_q <= 2'b00;
      seq_q      <= 12'd0;
      tim_out_q  <= 1'b0;
      retrain_q  <= 1'b0;
      crc_err_q  <= 1'b0;
      fmt_err_q  <= 1'b0;
      err_cnt_q  <= 8'd0;
      timer_q    <= 16'd0;
      rply_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      ack_nack_q <= ack_nack_d;
      seq_q      <= seq_d;
      tim_out_q  <= tim_out_d;
      retrain_q  <= retrain_d;
      crc_err_q  <= crc_err_d;
      fmt_err_q  <= fmt_err_d;
      err_cnt_q  <= err_cnt_d;
      timer_q    <= timer_d;
      rply_cnt_q <= rply_cnt_d;
    end
  end

  // NOTE: capture-only datapath registers need no reset; they are always written before the FSM reads them.
  always_ff @(posedge clk) begin
    type_q    <= type_d;
    seq_buf_q <= seq_buf_d;
    crc_q     <= crc_d;
  end

  assign bus.ack_nack = ack_nack_q;
  assign bus.seq      = seq_q;
  assign bus.tim_out  = tim_out_q;
  assign bus.retrain  = retrain_q;
  assign bus.crc_err  = crc_err_q;
  assign bus.fmt_err  = fmt_err_q;
  assign bus.err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_dllp_acknak_rx.sv
// Self-checking bench for dllp_acknak_rx (REPLAY_LIMIT = 16).
// Table of per-cycle vectors for the decoder, plus hand-written sequences for
// the replay timer, Ack/Nak vs timeout collisions, random stalls and reset.
module tb_dllp_acknak_rx;

  localparam logic [7:0] ACK = 8'h00;
  localparam logic [7:0] NAK = 8'h10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dllp_acknak_if ifc ();

  dllp_acknak_rx #(.REPLAY_LIMIT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  typedef struct {
    logic [15:0] din;
    logic        v;
    logic        sof;
    logic [1:0]  an;
    logic [11:0] seq;
    logic        ce;
    logic        fe;
    logic [7:0]  ec;
  } vec_t;

  vec_t vt[$];

  // Reference CRC: shift the 32-bit {word0,word1} through the register bit by bit.
  function automatic logic [15:0] ref_crc(input logic [31:0] d);
    logic [15:0] r;
    logic        fb;
    r = 16'hFFFF;
    for (int i = 31; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h100B;
    end
    return ~r;
  endfunction

  function automatic logic [15:0] w0(input logic [7:0] t);
    return {t, 8'h00};
  endfunction

  function automatic logic [15:0] w1(input logic [11:0] s);
    return {4'h0, s};
  endfunction

  function automatic logic [15:0] crcw(input logic [7:0] t, input logic [11:0] s);
    return ref_crc({w0(t), w1(s)});
  endfunction

  function automatic vec_t mk(input logic [15:0] din, input logic v, input logic sof,
                              input logic [1:0] an, input logic [11:0] seq,
                              input logic ce, input logic fe, input logic [7:0] ec);
    vec_t x;
    x.din = din; x.v = v; x.sof = sof; x.an = an; x.seq = seq;
    x.ce = ce; x.fe = fe; x.ec = ec;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] d, input logic v, input logic s);
    ifc.din       = d;
    ifc.din_valid = v;
    ifc.sof       = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    ifc.din       = 16'h0;
    ifc.din_valid = 1'b0;
    ifc.sof       = 1'b0;
    ifc.unacked   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] t, input logic [11:0] s);
    drive(w0(t), 1'b1, 1'b1);
    drive(w1(s), 1'b1, 1'b0);
    drive(crcw(t, s), 1'b1, 1'b0);
  endtask

  // Runs ncyc cycles with unacked high; a DLLP of type typ has its CRC word
  // accepted on edge dllp_edge (0 = no DLLP). Masks give expected pulses per edge.
  task automatic timer_seq(input string tag, input int ncyc, input int dllp_edge,
                           input logic [7:0] typ, input logic [128:0] tim_m,
                           input logic [128:0] rt_m);
    do_reset();
    ifc.unacked = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      if (dllp_edge > 0 && k == dllp_edge - 2)      drive(w0(typ), 1'b1, 1'b1);
      else if (dllp_edge > 0 && k == dllp_edge - 1) drive(w1(12'h055), 1'b1, 1'b0);
      else if (dllp_edge > 0 && k == dllp_edge)     drive(crcw(typ, 12'h055), 1'b1, 1'b0);
      else                                          drive(16'h0, 1'b0, 1'b0);
      check($sformatf("%s.tim_out@%0d", tag, k), 32'(ifc.tim_out), 32'(tim_m[k]));
      check($sformatf("%s.retrain@%0d", tag, k), 32'(ifc.retrain), 32'(rt_m[k]));
      if (k == dllp_edge)
        check($sformatf("%s.ack_nack@%0d", tag, k), 32'(ifc.ack_nack),
              (typ == ACK) ? 32'd1 : 32'd2);
    end
    ifc.unacked = 1'b0;
  endtask

  initial begin
    logic [128:0] tm;
    logic [128:0] rm;

    // ---------------- Reset state ----------------
    do_reset();
    check("reset.ack_nack", 32'(ifc.ack_nack), 32'd0);
    check("reset.seq",      32'(ifc.seq),      32'd0);
    check("reset.tim_out",  32'(ifc.tim_out),  32'd0);
    check("reset.retrain",  32'(ifc.retrain),  32'd0);
    check("reset.crc_err",  32'(ifc.crc_err),  32'd0);
    check("reset.fmt_err",  32'(ifc.fmt_err),  32'd0);
    check("reset.err_cnt",  32'(ifc.err_cnt),  32'd0);

    // ---------------- Decoder vector table ----------------
    // Good Ack seq 005
    vt.push_back(mk(w0(ACK),           1, 1, 2'd0, 12'h000, 0, 0, 8'd0));
    vt.push_back(mk(w1(12'h005),       1, 0, 2'd0, 12'h000, 0, 0, 8'd0));
    vt.push_back(mk(crcw(ACK, 12'h005),1, 0, 2'd1, 12'h005, 0, 0, 8'd0));
    vt.push_back(mk(16'h0000,          0, 0, 2'd0, 12'h005, 0, 0, 8'd0));
    // Same Ack with CRC bit 0 flipped
    vt.push_back(mk(w0(ACK),           1, 1, 2'd0, 12'h005, 0, 0, 8'd0));
    vt.push_back(mk(w1(12'h005),       1, 0, 2'd0, 12'h005, 0, 0, 8'd0));
    vt.push_back(mk(crcw(ACK, 12'h005) ^ 16'h0001, 1, 0, 2'd0, 12'h005, 1, 0, 8'd1));
    // Good Nak seq FFF
    vt.push_back(mk(w0(NAK),           1, 1, 2'd0, 12'h005, 0, 0, 8'd1));
    vt.push_back(mk(w1(12'hFFF),       1, 0, 2'd0, 12'h005, 0, 0, 8'd1));
    vt.push_back(mk(crcw(NAK, 12'hFFF),1, 0, 2'd2, 12'hFFF, 0, 0, 8'd1));
    // sof in W2 restarts; then full Ack 123
    vt.push_back(mk(w0(ACK),           1, 1, 2'd0, 12'hFFF, 0, 0, 8'd1));
    vt.push_back(mk(w1(12'h123),       1, 0, 2'd0, 12'hFFF, 0, 0, 8'd1));
    vt.push_back(mk(w0(ACK),           1, 1, 2'd0, 12'hFFF, 0, 1, 8'd2));
    vt.push_back(mk(w1(12'h123),       1, 0, 2'd0, 12'hFFF, 0, 0, 8'd2));
    vt.push_back(mk(crcw(ACK, 12'h123),1, 0, 2'd1, 12'h123, 0, 0, 8'd2));
    // Unknown type 20 with good CRC
    vt.push_back(mk(w0(8'h20),         1, 1, 2'd0, 12'h123, 0, 0, 8'd2));
    vt.push_back(mk(w1(12'h042),       1, 0, 2'd0, 12'h123, 0, 0, 8'd2));
    vt.push_back(mk(crcw(8'h20, 12'h042), 1, 0, 2'd0, 12'h123, 0, 1, 8'd3));
    // Nak ABC with stalls (an unqualified sof during a stall is ignored)
    vt.push_back(mk(w0(NAK),           1, 1, 2'd0, 12'h123, 0, 0, 8'd3));
    vt.push_back(mk(16'hBEEF,          0, 1, 2'd0, 12'h123, 0, 0, 8'd3));
    vt.push_back(mk(w1(12'hABC),       1, 0, 2'd0, 12'h123, 0, 0, 8'd3));
    vt.push_back(mk(16'hFFFF,          0, 0, 2'd0, 12'h123, 0, 0, 8'd3));
    vt.push_back(mk(crcw(NAK, 12'hABC),1, 0, 2'd2, 12'hABC, 0, 0, 8'd3));
    // Valid word without sof in IDLE is ignored; then Ack 7FF
    vt.push_back(mk(16'h1234,          1, 0, 2'd0, 12'hABC, 0, 0, 8'd3));
    vt.push_back(mk(w0(ACK),           1, 1, 2'd0, 12'hABC, 0, 0, 8'd3));
    vt.push_back(mk(w1(12'h7FF),       1, 0, 2'd0, 12'hABC, 0, 0, 8'd3));
    vt.push_back(mk(crcw(ACK, 12'h7FF),1, 0, 2'd1, 12'h7FF, 0, 0, 8'd3));
    // sof in W1 restarts as Nak 010
    vt.push_back(mk(w0(ACK),           1, 1, 2'd0, 12'h7FF, 0, 0, 8'd3));
    vt.push_back(mk(w0(NAK),           1, 1, 2'd0, 12'h7FF, 0, 1, 8'd4));
    vt.push_back(mk(w1(12'h010),       1, 0, 2'd0, 12'h7FF, 0, 0, 8'd4));
    vt.push_back(mk(crcw(NAK, 12'h010),1, 0, 2'd2, 12'h010, 0, 0, 8'd4));

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].din, vt[i].v, vt[i].sof);
      check($sformatf("vec%0d.ack_nack", i), 32'(ifc.ack_nack), 32'(vt[i].an));
      check($sformatf("vec%0d.seq", i),      32'(ifc.seq),      32'(vt[i].seq));
      check($sformatf("vec%0d.crc_err", i),  32'(ifc.crc_err),  32'(vt[i].ce));
      check($sformatf("vec%0d.fmt_err", i),  32'(ifc.fmt_err),  32'(vt[i].fe));
      check($sformatf("vec%0d.err_cnt", i),  32'(ifc.err_cnt),  32'(vt[i].ec));
      check($sformatf("vec%0d.tim_out", i),  32'(ifc.tim_out),  32'd0);
    end

    // ---------------- Replay timer, no DLLPs ----------------
    tm = '0; rm = '0;
    for (int k = 16; k <= 128; k += 16) tm[k] = 1'b1;
    rm[64] = 1'b1; rm[128] = 1'b1;
    timer_seq("timer", 128, 0, ACK, tm, rm);

    // Ack decoded on the edge the 3rd timeout would fire: count cleared
    tm = '0; rm = '0;
    tm[16] = 1'b1; tm[32] = 1'b1; tm[64] = 1'b1; tm[80] = 1'b1; tm[96] = 1'b1; tm[112] = 1'b1;
    rm[112] = 1'b1;
    timer_seq("ack_hit", 112, 48, ACK, tm, rm);

    // Nak on the same edge: timeout suppressed, count kept
    tm = '0; rm = '0;
    tm[16] = 1'b1; tm[32] = 1'b1; tm[64] = 1'b1; tm[80] = 1'b1; tm[96] = 1'b1;
    rm[80] = 1'b1;
    timer_seq("nak_hit", 96, 48, NAK, tm, rm);

    // ---------------- 50 random DLLPs with random stalls ----------------
    do_reset();
    for (int n = 0; n < 50; n++) begin
      logic [7:0]  t;
      logic [11:0] s;
      logic [15:0] w[3];
      t = ($urandom_range(0, 1) == 0) ? ACK : NAK;
      s = 12'($urandom);
      w[0] = w0(t); w[1] = w1(s); w[2] = crcw(t, s);
      for (int j = 0; j < 3; j++) begin
        int gaps;
        gaps = int'($urandom_range(0, 2));
        for (int g = 0; g < gaps; g++) begin
          drive(16'($urandom), 1'b0, 1'($urandom));
          check($sformatf("rnd%0d.stall.ack_nack", n), 32'(ifc.ack_nack), 32'd0);
        end
        drive(w[j], 1'b1, (j == 0));
        if (j == 2) begin
          check($sformatf("rnd%0d.ack_nack", n), 32'(ifc.ack_nack), (t == ACK) ? 32'd1 : 32'd2);
          check($sformatf("rnd%0d.seq", n), 32'(ifc.seq), 32'(s));
        end else begin
          check($sformatf("rnd%0d.w%0d.ack_nack", n, j), 32'(ifc.ack_nack), 32'd0);
        end
      end
    end
    check("rnd.err_cnt", 32'(ifc.err_cnt), 32'd0);

    // ---------------- Reset mid-DLLP ----------------
    drive(w0(ACK), 1'b1, 1'b1);
    drive(w1(12'h3C5), 1'b1, 1'b0);
    rst = 1'b1;
    drive(16'h0, 1'b0, 1'b0);
    rst = 1'b0;
    check("rst_mid.ack_nack", 32'(ifc.ack_nack), 32'd0);
    check("rst_mid.crc_err",  32'(ifc.crc_err),  32'd0);
    check("rst_mid.fmt_err",  32'(ifc.fmt_err),  32'd0);
    check("rst_mid.seq",      32'(ifc.seq),      32'd0);
    // The orphaned CRC word lands in IDLE and is dropped silently.
    drive(crcw(ACK, 12'h3C5), 1'b1, 1'b0);
    check("rst_mid.orphan.ack_nack", 32'(ifc.ack_nack), 32'd0);
    check("rst_mid.orphan.crc_err",  32'(ifc.crc_err),  32'd0);
    check("rst_mid.orphan.fmt_err",  32'(ifc.fmt_err),  32'd0);
    send(ACK, 12'h3C5);
    check("rst_mid.next.ack_nack", 32'(ifc.ack_nack), 32'd1);
    check("rst_mid.next.seq",      32'(ifc.seq),      32'h3C5);
    check("rst_mid.next.err_cnt",  32'(ifc.err_cnt),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
